// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the shared RAM/IO port: fetches, loads and stores are split into byte cycles.
// Optional feature macro: MEM_ARB_IO_STALL_EN (hold IO stores while the UART FIFO is full).
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic [31:0] ic_data,
    output logic        ic_done,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [2:0]  n_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        ic_done_q;
    logic        ls_done_q;
    logic [31:0] ic_data_q;
    logic [31:0] ls_rdata_q;

    logic [2:0]  k;
    logic [31:0] next_a;
    logic [31:0] rd_word;
    logic [7:0]  wbyte_next;
    logic [2:0]  ls_n;
    logic        io_stall;
    logic        grant_blk;

    assign k          = {1'b0, cnt_q} + 3'd1;
    assign next_a     = addr_q + {29'd0, k};
    assign wbyte_next = wdata_q[{k[1:0], 3'b000} +: 8];

    // Partial result with the byte arriving this cycle merged in
    always_comb begin
        rd_word = buf_q;
        rd_word[{cnt_q, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        case (ls_size)
            2'd0:    ls_n = 3'd1;
            2'd1:    ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
    end

`ifdef MEM_ARB_IO_STALL_EN
    assign io_stall  = io_buffer_full && (addr_q >= IO_BASE);
    assign grant_blk = io_buffer_full && (ls_addr >= IO_BASE);
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
    assign grant_blk = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            ic_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            ic_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else if (rdy) begin
            ic_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The done cycle is a bubble so requesters can drop req
                    if (!ic_done_q && !ls_done_q) begin
                        if (ls_req) begin
                            if (ls_wr && !grant_blk) begin
                                state_q    <= STORE;
                                mem_a_q    <= ls_addr;
                                mem_wr_q   <= 1'b1;
                                mem_dout_q <= ls_wdata[7:0];
                                cnt_q      <= 2'd0;
                                n_q        <= ls_n;
                                addr_q     <= ls_addr;
                                wdata_q    <= ls_wdata;
                            end else if (!ls_wr && !flush) begin
                                state_q <= LOAD;
                                mem_a_q <= ls_addr;
                                cnt_q   <= 2'd0;
                                n_q     <= ls_n;
                                addr_q  <= ls_addr;
                                buf_q   <= 32'd0;
                            end
                        end else if (ic_req && !flush) begin
                            state_q <= FETCH;
                            mem_a_q <= ic_addr;
                            cnt_q   <= 2'd0;
                            n_q     <= 3'd4;
                            addr_q  <= ic_addr;
                            buf_q   <= 32'd0;
                        end
                    end
                end
                FETCH, LOAD: begin
                    if (flush) begin
                        state_q <= IDLE;
                        mem_a_q <= 32'd0;
                    end else if (k == n_q) begin
                        state_q <= IDLE;
                        if (state_q == FETCH) begin
                            ic_data_q <= rd_word;
                            ic_done_q <= 1'b1;
                        end else begin
                            ls_rdata_q <= rd_word;
                            ls_done_q  <= 1'b1;
                        end
                    end else begin
                        buf_q   <= rd_word;
                        cnt_q   <= k[1:0];
                        mem_a_q <= next_a;
                    end
                end
                STORE: begin
                    // A byte only counts as written if mem_wr was high during the cycle
                    if (mem_wr_q) begin
                        if (k == n_q) begin
                            state_q   <= IDLE;
                            mem_wr_q  <= 1'b0;
                            mem_a_q   <= 32'd0;
                            ls_done_q <= 1'b1;
                        end else begin
                            cnt_q      <= k[1:0];
                            mem_a_q    <= next_a;
                            mem_dout_q <= wbyte_next;
                            mem_wr_q   <= !io_stall;
                        end
                    end else begin
                        mem_wr_q <= !io_stall;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign ic_done  = ic_done_q;
    assign ls_done  = ls_done_q;
    assign ic_data  = ic_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule
